ln_moment_unit: RTL

Parametrised first/second-moment engine for the AILayerNorm datapath. Accepts a stream of signed PTF-quantised activations over a runtime-selectable channel length. Each sample is scaled by its per-sample power-of-two factor, and the block accumulates the sum and the sum of squares. One multiply by 1/N (Q0.INV_W) then yields E[x] and E[x²] together. It sits upstream of the variance/normalisation stage and supersedes the fixed-length 8-sample mean unit.

---
 rtl/ln_pkg.sv | 26 ++
 rtl/ln_ptf_sq.sv | 26 ++
 rtl/ln_moment_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ln_pkg.sv
// Shared definitions for the LayerNorm moment and variance stages:
// FSM state encoding, derived width helpers and the default 1/N precision.
package ln_pkg;

   localparam int INV_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic int sx_w(input int data_w, input int alpha_w);
      return data_w + (1 << alpha_w) - 1;
   endfunction

   function automatic int sum_w(input int data_w, input int alpha_w, input int n_max);
      return sx_w(data_w, alpha_w) + $clog2(n_max);
   endfunction

   function automatic int sum2_w(input int data_w, input int alpha_w, input int n_max);
      return 2 * sx_w(data_w, alpha_w) + $clog2(n_max);
   endfunction

endpackage

// File: rtl/ln_ptf_sq.sv
// Combinational PTF rescale and square: sx = x <<< alpha (sign-extended), sq = sx*sx.
module ln_ptf_sq
   import ln_pkg::*;
#(
   parameter  int DATA_W  = 9,
   parameter  int ALPHA_W = 2,
   localparam int SX_W    = sx_w(DATA_W, ALPHA_W)
) (
   input  logic [DATA_W-1:0]  x,
   input  logic [ALPHA_W-1:0] alpha,
   output logic [SX_W-1:0]    sx,
   output logic [2*SX_W-1:0]  sq
);

   logic signed [SX_W-1:0]   x_ext;
   logic signed [SX_W-1:0]   sx_s;
   logic signed [2*SX_W-1:0] sx_wide;

   // SX_W leaves headroom for the largest shift, so the shift never overflows.
   assign x_ext   = {{(SX_W-DATA_W){x[DATA_W-1]}}, x};
   assign sx_s    = x_ext <<< alpha;
   assign sx_wide = {{SX_W{sx_s[SX_W-1]}}, sx_s};
   assign sq      = sx_wide * sx_wide;
   assign sx      = sx_s;

endmodule

// File: rtl/ln_moment_unit.sv
// First/second moment engine: accumulates sum and sum of squares over a
// runtime-length vector, then scales both by 1/N in a single MUL cycle.
module ln_moment_unit
   import ln_pkg::*;
#(
   parameter  int DATA_W  = 9,
   parameter  int ALPHA_W = 2,
   parameter  int N_MAX   = 64,
   parameter  int INV_W   = INV_W_DEF,
   localparam int SX_W    = sx_w(DATA_W, ALPHA_W),
   localparam int LG      = $clog2(N_MAX),
   localparam int SUM_W   = sum_w(DATA_W, ALPHA_W, N_MAX),
   localparam int SUM2_W  = sum2_w(DATA_W, ALPHA_W, N_MAX),
   localparam int LEN_W   = LG + 1
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [DATA_W-1:0]  i_x,
   input  logic [ALPHA_W-1:0] i_alpha,
   input  logic [LEN_W-1:0]   i_len,
   input  logic [INV_W-1:0]   i_inv_n,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [SUM_W-1:0]   o_ex,
   output logic [SUM2_W-1:0]  o_ex2,
   output logic               o_busy
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_ACC  = ACC;
   localparam logic [1:0] S_MUL  = MUL;
   localparam logic [1:0] S_DONE = DONE;

   localparam int PE_W  = SUM_W + INV_W + 1;
   localparam int PE2_W = SUM2_W + INV_W;

   logic [1:0]              state;
   logic [LEN_W-1:0]        len;
   logic [LEN_W-1:0]        cnt;
   logic [LEN_W-1:0]        len_in;
   logic [INV_W-1:0]        inv_n;
   logic signed [SUM_W-1:0] acc;
   logic [SUM2_W-1:0]       acc2;

   logic [SX_W-1:0]         sx;
   logic [2*SX_W-1:0]       sq;
   logic signed [SUM_W-1:0] sx_ext;
   logic [SUM2_W-1:0]       sq_ext;
   logic                    beat;

   logic signed [PE_W-1:0]  acc_w;
   logic signed [PE_W-1:0]  inv_w;
   logic signed [PE_W-1:0]  prod_ex;
   logic [PE2_W-1:0]        acc2_w;
   logic [PE2_W-1:0]        inv2_w;
   logic [PE2_W-1:0]        prod_ex2;
   logic                    unused_bits;

   ln_ptf_sq #(
      .DATA_W  (DATA_W),
      .ALPHA_W (ALPHA_W)
   ) u_ptf_sq (
      .x     (i_x),
      .alpha (i_alpha),
      .sx    (sx),
      .sq    (sq)
   );

   assign sx_ext  = {{(SUM_W-SX_W){sx[SX_W-1]}}, sx};
   assign sq_ext  = {{LG{1'b0}}, sq};
   assign o_ready = (state == S_IDLE) || (state == S_ACC);
   assign o_busy  = (state != S_IDLE);
   assign beat    = i_valid & o_ready;
   assign len_in  = (i_len == '0 || i_len > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : i_len;

   // 1/N scaling; keeping the integer bits of a full-width product is a floor shift.
   assign acc_w    = {{(INV_W+1){acc[SUM_W-1]}}, acc};
   assign inv_w    = {{(SUM_W+1){1'b0}}, inv_n};
   assign prod_ex  = acc_w * inv_w;
   assign acc2_w   = {{INV_W{1'b0}}, acc2};
   assign inv2_w   = {{SUM2_W{1'b0}}, inv_n};
   assign prod_ex2 = acc2_w * inv2_w;
   assign unused_bits = ^{prod_ex[INV_W-1:0], prod_ex[PE_W-1], prod_ex2[INV_W-1:0]};

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state   <= S_IDLE;
         len     <= '0;
         cnt     <= '0;
         inv_n   <= '0;
         acc     <= '0;
         acc2    <= '0;
         o_valid <= 1'b0;
         o_ex    <= '0;
         o_ex2   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (beat) begin
                  len   <= len_in;
                  inv_n <= i_inv_n;
                  acc   <= sx_ext;
                  acc2  <= sq_ext;
                  cnt   <= LEN_W'(1);
                  state <= (len_in == LEN_W'(1)) ? S_MUL : S_ACC;
               end
            end
            S_ACC: begin
               if (beat) begin
                  acc  <= acc + sx_ext;
                  acc2 <= acc2 + sq_ext;
                  cnt  <= cnt + LEN_W'(1);
                  if (cnt == len - LEN_W'(1)) state <= S_MUL;
               end
            end
            S_MUL: begin
               o_ex    <= prod_ex[INV_W +: SUM_W];
               o_ex2   <= prod_ex2[INV_W +: SUM2_W];
               o_valid <= 1'b1;
               state   <= S_DONE;
            end
            S_DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ex    <= '0;
                  o_ex2   <= '0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
